maroc_sc_readback: RTL and testbench

- Receive-side companion of the MAROC slow-control frame shifter.
- Deserializes the 829-bit configuration frame returned on the MAROC slow-control serial output (Q_SC) as the chain is clocked through, LSB first.
- Compares each returned bit against the frame that was sent, and reports per-frame match status, error count and first-error index to the control logic.
- Includes a bit-strobe watchdog so that a stalled readback terminates cleanly.

---
 rtl/maroc_sc_pkg.sv | 27 ++
 rtl/sc_bit_watchdog.sv | 31 +++
 rtl/maroc_sc_readback.sv | 137 +++++++++++++
 tb/tb_maroc_sc_readback.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/maroc_sc_pkg.sv
// Shared definitions for the MAROC slow-control frame path: frame length,
// field positions inside the frame, and the readback state encoding.
package maroc_sc_pkg;

  localparam int FRAME_LEN = 829;

  // Field positions inside the frame (bit 0 is the first bit on the wire).
  localparam int DAC2_LSB    = 3;
  localparam int DAC2_MSB    = 12;
  localparam int DAC1_LSB    = 13;
  localparam int DAC1_MSB    = 22;
  localparam int MASK_OR_LSB = 27;
  localparam int MASK_OR_MSB = 154;
  localparam int GAIN_LSB    = 189;
  localparam int GAIN_MSB    = 764;
  localparam int CTEST_LSB   = 765;
  localparam int CTEST_MSB   = 828;

  // Readback controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FINISH  = 2'd2,
    ST_ABORT   = 2'd3
  } sc_state_e;

endpackage

// File: rtl/sc_bit_watchdog.sv
// Bit-strobe watchdog: counts cycles since the last strobe and flags expiry
// once TIMEOUT-1 idle cycles have elapsed. Holds at the terminal count.
module sc_bit_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic CK_in,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] TERMINAL = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_count;

  assign o_expire = (r_count == TERMINAL);

  // Idle-cycle counter: cleared by a strobe, advances while enabled, saturates at terminal.
  always_ff @(posedge CK_in or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire) begin
      r_count <= r_count + WD_W'(1);
    end
  end

endmodule

// File: rtl/maroc_sc_readback.sv
// Receive side of the MAROC slow-control chain: deserializes Q_SC LSB first,
// compares every bit with the frame that was sent, and reports match status,
// mismatch count and first mismatch index. A watchdog aborts stalled captures.
module maroc_sc_readback
  import maroc_sc_pkg::*;
#(
  parameter int FRAME_LEN = maroc_sc_pkg::FRAME_LEN,
  parameter int CNT_W     = 10,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 CK_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_en,
  input  logic                 Q_SC,
  input  logic [FRAME_LEN-1:0] expected,
  output logic [FRAME_LEN-1:0] frame_out,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic                 timeout,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     first_err_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  sc_state_e            r_state;
  logic [FRAME_LEN-1:0] r_frame;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_err;
  logic [CNT_W-1:0]     r_first;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_match;
  logic                 r_timeout;

  logic                 w_capture;
  logic                 w_take;
  logic                 w_mismatch;
  logic                 w_wd_expire;
  logic [CNT_W-1:0]     w_err_next;

  assign w_capture  = (r_state == ST_CAPTURE);
  assign w_take     = w_capture && bit_en;
  assign w_mismatch = Q_SC ^ expected[r_cnt];

  sc_bit_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CK_in    (CK_in),
    .rst      (rst),
    .i_clear  (!w_capture || bit_en),
    .i_enable (w_capture),
    .o_expire (w_wd_expire)
  );

  // Mismatch count including the bit being taken this cycle, saturating at all-ones.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_err_next = r_err;
    if (w_take && w_mismatch && (r_err != '1)) begin
      w_err_next = r_err + CNT_W'(1);
    end
  end

  // Capture FSM with deserializer, comparator and registered status outputs.
  always_ff @(posedge CK_in or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, avoiding order-dependent races.
    if (rst) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      r_cnt     <= '0;
      r_err     <= '0;
      r_first   <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // A bit_en coincident with start is deliberately not taken.
          if (start) begin
            r_state   <= ST_CAPTURE;
            r_busy    <= 1'b1;
            r_frame   <= '0;
            r_cnt     <= '0;
            r_err     <= '0;
            r_first   <= '1;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          // A strobe wins over a watchdog expiring in the same cycle.
          if (bit_en) begin
            r_frame <= {Q_SC, r_frame[FRAME_LEN-1:1]};
            r_err   <= w_err_next;
            if (w_mismatch && (r_err == '0)) begin
              r_first <= r_cnt;
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_IDX) begin
              r_state <= ST_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_match <= (w_err_next == '0);
            end
          end else if (w_wd_expire) begin
            r_state   <= ST_ABORT;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_match   <= 1'b0;
          end
        end
        ST_FINISH, ST_ABORT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign frame_out     = r_frame;
  assign busy          = r_busy;
  assign done          = r_done;
  assign match         = r_match;
  assign timeout       = r_timeout;
  assign err_count     = r_err;
  assign first_err_idx = r_first;

endmodule

// File: tb/tb_maroc_sc_readback.sv
// Directed testbench for maroc_sc_readback: good frame, two-bit error frame,
// watchdog abort, ignored start/bit_en cases, mid-capture reset, and an
// all-mismatch frame with a strobe on the watchdog terminal cycle.
module tb_maroc_sc_readback;
  import maroc_sc_pkg::*;

  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 1024;

  logic                 CK_in  = 1'b0;
  logic                 rst    = 1'b1;
  logic                 start  = 1'b0;
  logic                 bit_en = 1'b0;
  logic                 Q_SC   = 1'b0;
  logic [FRAME_LEN-1:0] expected;
  logic [FRAME_LEN-1:0] frame_out;
  logic                 busy;
  logic                 done;
  logic                 match;
  logic                 timeout;
  logic [CNT_W-1:0]     err_count;
  logic [CNT_W-1:0]     first_err_idx;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;

  maroc_sc_readback #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CK_in         (CK_in),
    .rst           (rst),
    .start         (start),
    .bit_en        (bit_en),
    .Q_SC          (Q_SC),
    .expected      (expected),
    .frame_out     (frame_out),
    .busy          (busy),
    .done          (done),
    .match         (match),
    .timeout       (timeout),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  always #5 CK_in = ~CK_in;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Number of bits where frame_out differs from want; 9999 if frame_out carries X/Z.
  function automatic logic [63:0] frame_diff(input logic [FRAME_LEN-1:0] want);
    if ((^frame_out) === 1'bx) return 64'd9999;
    return 64'($countones(frame_out ^ want));
  endfunction

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge CK_in);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sends FRAME_LEN strobes of expected^flip. gap_len idle cycles precede bit gap_idx;
  // start is raised together with strobe start_idx.
  task automatic run_frame(input logic [FRAME_LEN-1:0] flip, input int gap_idx,
                           input int gap_len, input int start_idx);
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (k == gap_idx) repeat (gap_len) step();
      bit_en = 1'b1;
      Q_SC   = expected[k] ^ flip[k];
      start  = (k == start_idx);
      step();
      bit_en = 1'b0;
      start  = 1'b0;
    end
    step();
    step();
  endtask

  logic [FRAME_LEN-1:0] flip;
  logic [FRAME_LEN-1:0] partial;
  int d0;
  int n;

  initial begin
    for (int k = 0; k < FRAME_LEN; k++) expected[k] = ~k[0];

    // Reset state
    repeat (3) step();
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_match", 64'(match), 0);
    check("rst_timeout", 64'(timeout), 0);
    check("rst_err", 64'(err_count), 0);
    check("rst_first", 64'(first_err_idx), 1023);
    check("rst_frame", frame_diff('0), 0);
    rst = 1'b0;
    step();

    // 1: clean frame
    d0 = done_seen;
    pulse_start();
    check("t1_busy", 64'(busy), 1);
    run_frame('0, -1, 0, -1);
    check("t1_done", 64'(done_seen - d0), 1);
    check("t1_match", 64'(match), 1);
    check("t1_err", 64'(err_count), 0);
    check("t1_first", 64'(first_err_idx), 1023);
    check("t1_frame", frame_diff(expected), 0);
    check("t1_busy_low", 64'(busy), 0);

    // 2: bits 40 and 700 inverted
    flip = '0;
    flip[40]  = 1'b1;
    flip[700] = 1'b1;
    d0 = done_seen;
    pulse_start();
    run_frame(flip, -1, 0, -1);
    check("t2_done", 64'(done_seen - d0), 1);
    check("t2_match", 64'(match), 0);
    check("t2_err", 64'(err_count), 2);
    check("t2_first", 64'(first_err_idx), 40);
    check("t2_frame", frame_diff(expected ^ flip), 0);

    // 3: stall after 100 strobes
    d0 = done_seen;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      bit_en = 1'b1;
      Q_SC   = expected[k];
      step();
      bit_en = 1'b0;
    end
    n = 0;
    while (done_seen == d0 && n < 1100) begin
      step();
      n++;
    end
    check("t3_abort_latency", 64'(n), 1024);
    check("t3_busy", 64'(busy), 0);
    repeat (3) step();
    check("t3_done", 64'(done_seen - d0), 1);
    check("t3_timeout", 64'(timeout), 1);
    check("t3_match", 64'(match), 0);
    check("t3_err", 64'(err_count), 0);
    partial = '0;
    for (int k = 0; k < 100; k++) partial[FRAME_LEN - 100 + k] = expected[k];
    check("t3_partial", frame_diff(partial), 0);

    // 4: bit_en in IDLE ignored, start+bit_en coincident, second start at strobe 300
    bit_en = 1'b1;
    Q_SC   = 1'b1;
    step();
    bit_en = 1'b0;
    check("t4_idle_bit", frame_diff(partial), 0);
    d0 = done_seen;
    start  = 1'b1;
    bit_en = 1'b1;
    Q_SC   = ~expected[0];
    step();
    start  = 1'b0;
    bit_en = 1'b0;
    check("t4_timeout_clr", 64'(timeout), 0);
    check("t4_busy", 64'(busy), 1);
    check("t4_err0", 64'(err_count), 0);
    run_frame('0, -1, 0, 299);
    check("t4_done", 64'(done_seen - d0), 1);
    check("t4_match", 64'(match), 1);
    check("t4_err", 64'(err_count), 0);
    check("t4_frame", frame_diff(expected), 0);

    // 5: reset mid-capture
    d0 = done_seen;
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      bit_en = 1'b1;
      Q_SC   = expected[k] ^ (k == 10);
      step();
      bit_en = 1'b0;
    end
    check("t5_err_pre", 64'(err_count), 1);
    check("t5_first_pre", 64'(first_err_idx), 10);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_busy", 64'(busy), 0);
    check("t5_async_err", 64'(err_count), 0);
    check("t5_async_first", 64'(first_err_idx), 1023);
    check("t5_async_frame", frame_diff('0), 0);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("t5_no_done", 64'(done_seen - d0), 0);
    d0 = done_seen;
    pulse_start();
    run_frame('0, -1, 0, -1);
    check("t5_done", 64'(done_seen - d0), 1);
    check("t5_match", 64'(match), 1);

    // 6: all bits inverted, strobe on the watchdog terminal cycle before bit 50
    d0 = done_seen;
    pulse_start();
    run_frame('1, 50, TIMEOUT - 1, -1);
    check("t6_done", 64'(done_seen - d0), 1);
    check("t6_timeout", 64'(timeout), 0);
    check("t6_match", 64'(match), 0);
    check("t6_err", 64'(err_count), 829);
    check("t6_first", 64'(first_err_idx), 0);
    check("t6_frame", frame_diff(~expected), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
